// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU sharing logic: default operand/select widths,
// ALUOP encodings and the reserved-opcode test (any opcode with bit 2 set).
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_OP_WIDTH   = 3;

    localparam logic [DEFAULT_OP_WIDTH-1:0] ALU_FWD = 3'b000;
    localparam logic [DEFAULT_OP_WIDTH-1:0] ALU_ADD = 3'b001;
    localparam logic [DEFAULT_OP_WIDTH-1:0] ALU_AND = 3'b010;
    localparam logic [DEFAULT_OP_WIDTH-1:0] ALU_OR  = 3'b011;

    // Opcodes 1xx are reserved: the ALU is driven with FWD and an error is flagged.
    function automatic logic is_reserved(input logic [DEFAULT_OP_WIDTH-1:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter. A requester competes only when it is both
// requesting and eligible. Ties go to the requester named by the pointer; after
// a grant to requester i the pointer moves to the other requester.
// Ports:
//   CLK, RESET_N  clock (rising edge), asynchronous active-low reset
//   req[1:0]      request per requester
//   eligible[1:0] requester may be granted this cycle
//   grant[1:0]    combinational one-hot (or zero) grant
// -----------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [1:0] req,
    input  logic [1:0] eligible,
    output logic [1:0] grant
);

    logic       ptr_r;
    logic [1:0] cand_s;

    // Grant decision from qualified requests and the priority pointer.
    always_comb begin
        cand_s = req & eligible;
        grant  = 2'b00;
        case (cand_s)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_r ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Priority pointer: points away from the most recent winner, holds when idle.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ptr_r <= 1'b0;
        end else if (grant[0]) begin
            ptr_r <= 1'b1;
        end else if (grant[1]) begin
            ptr_r <= 1'b0;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one external combinational ALU between two requesters. One request is
// granted per cycle (round-robin), its operands drive the ALU, and the ALU
// result is captured one edge later into that requester's response slot.
// Ports:
//   CLK, RESET_N                 clock, asynchronous active-low reset
//   req_valid/req_ready[1:0]     request handshake per requester
//   req_op/req_a/req_b           packed per-requester opcode and operands
//   rsp_valid/rsp_ready[1:0]     response handshake per requester
//   rsp_result, rsp_err          packed per-requester result and reserved-op flag
//   alu_data1/2, alu_select      drive to the shared ALU
//   alu_result                   combinational ALU result
// -----------------------------------------------------------------------------
module alu_arbiter import alu_pkg::*; #(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int OP_WIDTH   = DEFAULT_OP_WIDTH
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [2*OP_WIDTH-1:0]   req_op,
    input  logic [2*DATA_WIDTH-1:0] req_a,
    input  logic [2*DATA_WIDTH-1:0] req_b,
    output logic [1:0]              rsp_valid,
    input  logic [1:0]              rsp_ready,
    output logic [2*DATA_WIDTH-1:0] rsp_result,
    output logic [1:0]              rsp_err,
    output logic [DATA_WIDTH-1:0]   alu_data1,
    output logic [DATA_WIDTH-1:0]   alu_data2,
    output logic [OP_WIDTH-1:0]     alu_select,
    input  logic [DATA_WIDTH-1:0]   alu_result
);

    logic [OP_WIDTH-1:0]     op_s [2];
    logic [DATA_WIDTH-1:0]   a_s  [2];
    logic [DATA_WIDTH-1:0]   b_s  [2];
    logic [1:0]              reserved_s;
    logic [1:0]              eligible_s;
    logic [1:0]              grant_s;
    logic [1:0]              rsp_valid_r;
    logic [1:0]              rsp_err_r;
    logic [2*DATA_WIDTH-1:0] rsp_result_r;

    // Unpack per-requester fields; a slot can accept when empty or draining now.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            op_s[i]       = req_op[i*OP_WIDTH +: OP_WIDTH];
            a_s[i]        = req_a[i*DATA_WIDTH +: DATA_WIDTH];
            b_s[i]        = req_b[i*DATA_WIDTH +: DATA_WIDTH];
            reserved_s[i] = is_reserved(op_s[i]);
            eligible_s[i] = ~rsp_valid_r[i] | rsp_ready[i];
        end
    end

    rr_arbiter2 u_rr_arbiter2 (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .req      (req_valid),
        .eligible (eligible_s),
        .grant    (grant_s)
    );

    assign req_ready  = grant_s;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_err    = rsp_err_r;
    assign rsp_result = rsp_result_r;

    // ALU operand mux; reserved opcodes run as FWD, idle cycles drive zeros.
    always_comb begin
        alu_data1  = {DATA_WIDTH{1'b0}};
        alu_data2  = {DATA_WIDTH{1'b0}};
        alu_select = ALU_FWD;
        if (grant_s[0]) begin
            alu_data1  = a_s[0];
            alu_data2  = b_s[0];
            alu_select = reserved_s[0] ? ALU_FWD : op_s[0];
        end else if (grant_s[1]) begin
            alu_data1  = a_s[1];
            alu_data2  = b_s[1];
            alu_select = reserved_s[1] ? ALU_FWD : op_s[1];
        end else begin
            alu_data1  = {DATA_WIDTH{1'b0}};
            alu_data2  = {DATA_WIDTH{1'b0}};
            alu_select = ALU_FWD;
        end
    end

    // Response slots: refill on grant, clear valid on drain, otherwise hold.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rsp_valid_r  <= 2'b00;
            rsp_err_r    <= 2'b00;
            rsp_result_r <= {(2*DATA_WIDTH){1'b0}};
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (grant_s[i]) begin
                    rsp_valid_r[i] <= 1'b1;
                    rsp_err_r[i]   <= reserved_s[i];
                    rsp_result_r[i*DATA_WIDTH +: DATA_WIDTH] <=
                        reserved_s[i] ? {DATA_WIDTH{1'b0}} : alu_result;
                end else if (rsp_valid_r[i] && rsp_ready[i]) begin
                    rsp_valid_r[i] <= 1'b0;
                end else begin
                    rsp_valid_r[i] <= rsp_valid_r[i];
                end
            end
        end
    end

endmodule
